alu_issue_ctrl: RTL

Sequencing stage that sits directly upstream of the 4-bit `ALU` and drives its `A`, `B` and `ALUop` inputs. It holds a 4-entry operand register file and accepts 8-bit register-to-register instructions over a valid/ready handshake. It issues each instruction to the ALU with registered operands, captures `Result` back into the destination register, and returns it over a valid/ready response channel. The ALU stays a separate combinational block; this block never interprets `ALUop`.

---
 rtl/alu_issue_pkg.sv | 44 ++++
 rtl/alu_issue_rf.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue controller.
// Instruction layout: {op[7:6], rd[5:4], ra[3:2], rb[1:0]}.
package alu_issue_pkg;

  localparam int unsigned NREG  = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned IW    = 8;
  localparam int unsigned OPW   = 2;
  localparam int unsigned CNT_W = 8;

  localparam int unsigned OP_MSB = 7;
  localparam int unsigned OP_LSB = 6;
  localparam int unsigned RD_MSB = 5;
  localparam int unsigned RD_LSB = 4;
  localparam int unsigned RA_MSB = 3;
  localparam int unsigned RA_LSB = 2;
  localparam int unsigned RB_MSB = 1;
  localparam int unsigned RB_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [AW-1:0]  rd;
    logic [AW-1:0]  ra;
    logic [AW-1:0]  rb;
  } instr_t;

  // Split a raw instruction word into its fields.
  function automatic instr_t decode_instr(input logic [IW-1:0] raw);
    instr_t d;
    d.op = raw[OP_MSB:OP_LSB];
    d.rd = raw[RD_MSB:RD_LSB];
    d.ra = raw[RA_MSB:RA_LSB];
    d.rb = raw[RB_MSB:RB_LSB];
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_rf.sv
// Operand register file: two asynchronous read ports, two write ports
// where port 0 (result writeback) has priority over port 1 (host).
module alu_issue_rf
  import alu_issue_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr0,
  output logic [W-1:0]  rd_data0,
  input  logic [AW-1:0] rd_addr1,
  output logic [W-1:0]  rd_data1,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [W-1:0]  wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [W-1:0]  wd1
);

  logic [W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we0 && (wa0 == AW'(i)))      regs[i] <= wd0;
        else if (we1 && (wa1 == AW'(i))) regs[i] <= wd1;
      end
    end
  end

  // Reads see the pre-edge contents; no write-to-read bypass.
  assign rd_data0 = regs[rd_addr0];
  assign rd_data1 = regs[rd_addr1];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one register-to-register instruction at a time to an external
// combinational ALU, writes the result back and returns it to the consumer.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_instr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [W-1:0]     alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  state_t       state;
  state_t       state_nxt;
  instr_t       instr_q;
  logic         accept;
  logic         issue_en;
  logic         capt_en;
  logic         resp_done;
  logic [W-1:0] rf_a;
  logic [W-1:0] rf_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state strobes; in_ready is forced low while reset is asserted.
  always_comb begin
    in_ready  = 1'b0;
    accept    = 1'b0;
    issue_en  = 1'b0;
    capt_en   = 1'b0;
    resp_done = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        accept   = in_valid & ~rst;
      end
      ISSUE:   issue_en  = 1'b1;
      CAPT:    capt_en   = 1'b1;
      RESP:    resp_done = out_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      out_data  <= '0;
      out_zero  <= 1'b1;
      out_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      if (accept) instr_q <= decode_instr(in_instr);
      if (issue_en) begin
        alu_a  <= rf_a;
        alu_b  <= rf_b;
        alu_op <= instr_q.op;
      end
      if (capt_en) begin
        out_data  <= alu_result;
        out_zero  <= (alu_result == '0);
        out_valid <= 1'b1;
      end
      if (resp_done) begin
        out_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

  alu_issue_rf #(.W(W)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rd_addr0 (instr_q.ra),
    .rd_data0 (rf_a),
    .rd_addr1 (instr_q.rb),
    .rd_data1 (rf_b),
    .we0      (capt_en),
    .wa0      (instr_q.rd),
    .wd0      (alu_result),
    .we1      (wr_en),
    .wa1      (wr_addr),
    .wd1      (wr_data)
  );

endmodule
